mem_wb_stage: RTL and testbench

//  MEM/WB writeback stage: sole driver of regfile write port (wb_flag/wb_address/wb_data).
//  ALU results retire next cycle. Loads wait for the data-memory response (FSM),

---
 rtl/mem_wb_stage_pkg.sv | 26 ++
 rtl/mem_wb_stage_load_ext.sv | 49 ++++
 rtl/mem_wb_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
//==============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared widths, load funct3 codes and FSM states for mem_wb_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_wb_stage_pkg;

    localparam int c_data_size         = 32;
    localparam int c_data_address_size = 5;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_load_ext.sv
//==============================================================================
// Module      : mem_wb_stage_load_ext
// Description : Load byte/half selection and sign/zero extension.
//               Active only with WB_LOAD_EXT_EN defined; otherwise passes the raw word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_wb_stage_load_ext
    import mem_wb_stage_pkg::*;
(
    input  logic [c_data_size-1:0] data,
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr_lo,
    output logic [c_data_size-1:0] result
);

`ifdef WB_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = data[7:0];
            2'd1:    w_byte = data[15:8];
            2'd2:    w_byte = data[23:16];
            default: w_byte = data[31:24];
        endcase
        // Halfword selection ignores addr_lo[0].
        w_half = addr_lo[1] ? data[31:16] : data[15:0];

        case (funct3)
            c_f3_lb:  result = {{24{w_byte[7]}}, w_byte};
            c_f3_lbu: result = {24'd0, w_byte};
            c_f3_lh:  result = {{16{w_half[15]}}, w_half};
            c_f3_lhu: result = {16'd0, w_half};
            default:  result = data;
        endcase
    end
`else
    logic w_unused;

    assign w_unused = ^{funct3, addr_lo};
    assign result   = data;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
//==============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB writeback stage; sole regfile write-port driver with a
//               load-wait FSM, upstream stall and timeout watchdog.
//               Optional macro WB_LOAD_EXT_EN enables byte/half load extension.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int LD_TIMEOUT = 16
)
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_valid,
    input  logic                             mem_rd_flag,
    input  logic [c_data_address_size-1:0]   mem_rd_address,
    input  logic [c_data_size-1:0]           mem_alu_data,
    input  logic                             mem_is_load,
    input  logic [2:0]                       mem_load_funct3,
    input  logic [1:0]                       mem_addr_lo,
    input  logic                             ld_ack,
    input  logic [c_data_size-1:0]           ld_data,
    output logic                             stall_req,
    output logic                             ld_err,
    output logic                             wb_flag,
    output logic [c_data_address_size-1:0]   wb_address,
    output logic [c_data_size-1:0]           wb_data
);

    localparam int c_cnt_w = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(LD_TIMEOUT - 1);

    wb_state_t                        r_state, w_state_nxt;
    logic [c_cnt_w-1:0]               r_cnt, w_cnt_nxt;
    logic                             r_hold_wr, w_hold_wr_nxt;
    logic [c_data_address_size-1:0]   r_hold_rd, w_hold_rd_nxt;
    logic [2:0]                       r_hold_f3, w_hold_f3_nxt;
    logic [1:0]                       r_hold_lo, w_hold_lo_nxt;

    logic                             r_wb_flag, w_wb_flag_nxt;
    logic [c_data_address_size-1:0]   r_wb_addr, w_wb_addr_nxt;
    logic [c_data_size-1:0]           r_wb_data, w_wb_data_nxt;
    logic                             r_ld_err, w_ld_err_nxt;

    logic                             w_stall;
    logic                             w_mem_wr;
    logic [2:0]                       w_ext_f3;
    logic [1:0]                       w_ext_lo;
    logic [c_data_size-1:0]           w_ext_data;

    assign w_mem_wr = mem_rd_flag & (mem_rd_address != '0);

    mem_wb_stage_load_ext u_load_ext (
        .data    (ld_data),
        .funct3  (w_ext_f3),
        .addr_lo (w_ext_lo),
        .result  (w_ext_data)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hold_wr_nxt = r_hold_wr;
        w_hold_rd_nxt = r_hold_rd;
        w_hold_f3_nxt = r_hold_f3;
        w_hold_lo_nxt = r_hold_lo;
        w_wb_flag_nxt = 1'b0;
        w_wb_addr_nxt = '0;
        w_wb_data_nxt = '0;
        w_ld_err_nxt  = 1'b0;
        w_stall       = 1'b0;
        w_ext_f3      = mem_load_funct3;
        w_ext_lo      = mem_addr_lo;

        case (r_state)
            IDLE: begin
                if (mem_valid && !mem_is_load) begin
                    w_wb_flag_nxt = w_mem_wr;
                    if (w_mem_wr) begin
                        w_wb_addr_nxt = mem_rd_address;
                        w_wb_data_nxt = mem_alu_data;
                    end
                end else if (mem_valid && mem_is_load) begin
                    if (ld_ack) begin
                        w_wb_flag_nxt = w_mem_wr;
                        if (w_mem_wr) begin
                            w_wb_addr_nxt = mem_rd_address;
                            w_wb_data_nxt = w_ext_data;
                        end
                    end else begin
                        w_stall       = 1'b1;
                        w_state_nxt   = WAIT_LD;
                        w_cnt_nxt     = '0;
                        w_hold_wr_nxt = w_mem_wr;
                        w_hold_rd_nxt = mem_rd_address;
                        w_hold_f3_nxt = mem_load_funct3;
                        w_hold_lo_nxt = mem_addr_lo;
                    end
                end
            end
            WAIT_LD: begin
                // Upstream is frozen, so the captured load fields drive extension.
                w_ext_f3 = r_hold_f3;
                w_ext_lo = r_hold_lo;
                w_stall  = !ld_ack;
                if (ld_ack) begin
                    w_state_nxt   = IDLE;
                    w_wb_flag_nxt = r_hold_wr;
                    if (r_hold_wr) begin
                        w_wb_addr_nxt = r_hold_rd;
                        w_wb_data_nxt = w_ext_data;
                    end
                end else if ((LD_TIMEOUT != 0) && (r_cnt == c_cnt_last)) begin
                    w_state_nxt  = IDLE;
                    w_ld_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hold_wr <= 1'b0;
            r_hold_rd <= '0;
            r_hold_f3 <= '0;
            r_hold_lo <= '0;
            r_wb_flag <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_ld_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hold_wr <= w_hold_wr_nxt;
            r_hold_rd <= w_hold_rd_nxt;
            r_hold_f3 <= w_hold_f3_nxt;
            r_hold_lo <= w_hold_lo_nxt;
            r_wb_flag <= w_wb_flag_nxt;
            r_wb_addr <= w_wb_addr_nxt;
            r_wb_data <= w_wb_data_nxt;
            r_ld_err  <= w_ld_err_nxt;
        end
    end

    assign stall_req  = w_stall & !rst;
    assign ld_err     = r_ld_err;
    assign wb_flag    = r_wb_flag;
    assign wb_address = r_wb_addr;
    assign wb_data    = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
//==============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed and random stimulus against a transaction-level model
//               of the writeback stage (honours WB_LOAD_EXT_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_rd_flag;
    logic [4:0]  mem_rd_address;
    logic [31:0] mem_alu_data;
    logic        mem_is_load;
    logic [2:0]  mem_load_funct3;
    logic [1:0]  mem_addr_lo;
    logic        ld_ack;
    logic [31:0] ld_data;
    logic        stall_req;
    logic        ld_err;
    logic        wb_flag;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;

    int n_pass  = 0;
    int n_total = 0;

    // Model: one outstanding load remembered as a record plus a wait counter.
    bit          m_busy  = 0;
    bit          m_wr    = 0;
    bit [4:0]    m_rd    = 0;
    bit [2:0]    m_f3    = 0;
    bit [1:0]    m_lo    = 0;
    int          m_waits = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.LD_TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid       (mem_valid),
        .mem_rd_flag     (mem_rd_flag),
        .mem_rd_address  (mem_rd_address),
        .mem_alu_data    (mem_alu_data),
        .mem_is_load     (mem_is_load),
        .mem_load_funct3 (mem_load_funct3),
        .mem_addr_lo     (mem_addr_lo),
        .ld_ack          (ld_ack),
        .ld_data         (ld_data),
        .stall_req       (stall_req),
        .ld_err          (ld_err),
        .wb_flag         (wb_flag),
        .wb_address      (wb_address),
        .wb_data         (wb_data)
    );

    function automatic logic [31:0] m_ext(input logic [31:0] d, input logic [2:0] f3,
                                          input logic [1:0] lo);
`ifdef WB_LOAD_EXT_EN
        int unsigned b, h;
        b = (d >> (8 * lo)) % 256;
        h = (d >> (16 * (lo / 2))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
`else
        return (f3 == f3 && lo == lo) ? d : d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycle(input bit r, input bit v, input bit rf, input bit [4:0] rd,
                         input bit [31:0] alu, input bit ld, input bit [2:0] f3,
                         input bit [1:0] lo, input bit ack, input bit [31:0] d);
        bit        e_stall, e_flag, e_err, wr;
        bit [4:0]  e_addr;
        bit [31:0] e_data;
        @(negedge clk);
        rst = r; mem_valid = v; mem_rd_flag = rf; mem_rd_address = rd;
        mem_alu_data = alu; mem_is_load = ld; mem_load_funct3 = f3;
        mem_addr_lo = lo; ld_ack = ack; ld_data = d;

        e_stall = 0; e_flag = 0; e_err = 0; e_addr = 0; e_data = 0;
        wr = rf && (rd != 0);
        if (r) begin
            m_busy = 0;
            m_waits = 0;
        end else if (!m_busy) begin
            if (v && !ld) begin
                e_flag = wr;
                if (wr) begin e_addr = rd; e_data = alu; end
            end else if (v && ld && ack) begin
                e_flag = wr;
                if (wr) begin e_addr = rd; e_data = m_ext(d, f3, lo); end
            end else if (v && ld) begin
                e_stall = 1;
                m_busy = 1; m_waits = 0;
                m_wr = wr; m_rd = rd; m_f3 = f3; m_lo = lo;
            end
        end else if (ack) begin
            m_busy = 0;
            e_flag = m_wr;
            if (m_wr) begin e_addr = m_rd; e_data = m_ext(d, m_f3, m_lo); end
        end else begin
            e_stall = 1;
            m_waits++;
            if (TO != 0 && m_waits == TO) begin
                m_busy = 0;
                e_err = 1;
            end
        end

        #1;
        check("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
        @(posedge clk);
        #1;
        check("wb_flag", {31'd0, wb_flag}, {31'd0, e_flag});
        check("wb_address", {27'd0, wb_address}, {27'd0, e_addr});
        check("wb_data", wb_data, e_data);
        check("ld_err", {31'd0, ld_err}, {31'd0, e_err});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 3, 32'h55, 1, 0, 0, 0, 0);

        // ALU write, then bus returns to zero
        cycle(0, 1, 1, 5, 32'h0000_1234, 0, 0, 0, 0, 0);
        check("alu_const", wb_data, 32'h0000_1234);
        idle();

        // rd = 0 never written (ALU and zero-wait load)
        cycle(0, 1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 32'h0, 1, 3'b010, 0, 1, 32'hDEAD_BEEF);

        // LB with three wait cycles, then LBU
        for (int k = 0; k < 2; k++) begin
            cycle(0, 1, 1, 7, 0, 1, (k == 0) ? 3'b000 : 3'b100, 1, 0, 0);
            for (int w = 0; w < 3; w++)
                cycle(0, 1, 1, 7, 0, 1, (k == 0) ? 3'b000 : 3'b100, 1, 0, 0);
            cycle(0, 1, 1, 7, 0, 1, (k == 0) ? 3'b000 : 3'b100, 1, 1, 32'h0000_80FF);
            idle();
        end

        // LHU zero-wait
        cycle(0, 1, 1, 9, 0, 1, 3'b101, 2, 1, 32'hBEEF_0000);
        idle();

        // Timeout
        cycle(0, 1, 1, 4, 0, 1, 3'b010, 0, 0, 0);
        for (int w = 0; w < TO; w++) cycle(0, 1, 1, 4, 0, 1, 3'b010, 0, 0, 0);
        idle();

        // Reset while waiting, late ack ignored
        cycle(0, 1, 1, 6, 0, 1, 3'b010, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222);
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit [4:0] rd;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  rd, $urandom(), 1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 7)],
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
